// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sharing one full-adder cell, LSB first.
// Latency: done is high WIDTH cycles after the accept edge; busy for WIDTH+1 cycles.
// Backpressure: start is honoured only in IDLE; pulses in RUN/DONE are dropped, not queued.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // The single shared one-bit full adder.
    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_cout  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign res_next = {fa_sum, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = res_next[WIDTH-1:1];
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // carry_q is the carry into the MSB on this final bit.
                    sum_d   = res_next;
                    cout_d  = fa_cout;
                    ovf_d   = fa_cout ^ carry_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that time-shares a single `Full_adder` instance across a WIDTH-bit operation, processing one bit per clock, LSB first. It sits between a requester, which issues start-pulse operands, and the one-bit adder datapath. It trades WIDTH cycles of latency for one full-adder cell. It owns the operand/result shift registers, the carry flop, the bit counter and the start/done handshake.

## Interface
- `WIDTH`, default 8, operand/result width in bits (≥2).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `sub` input 1: 0 = add, 1 = subtract (a − b); sampled with `start`.
- `cin` input 1: carry-in for add mode; ignored when `sub`=1.
- `a` input WIDTH: operand A; sampled with `start`.
- `b` input WIDTH: operand B; sampled with `start`.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse; result valid.
- `sum` output WIDTH: result; held from `done` until next accepted `start`.
- `cout` output 1: final carry out; in subtract mode 1 = no borrow.
- `ovf` output 1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- One clock; reset is asynchronous and active-low (`rst_n`).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On `start`=1, load A shift reg ← `a`.
  - Load B shift reg ← `sub ? ~b : b`.
  - Load carry ← `sub ? 1 : cin`.
  - Clear bit counter to 0; go to RUN.
- RUN, each cycle:
  - The adder sees A[0], B[0] and the carry.
  - Shift the adder Sum into the result register MSB while the result shifts right.
  - Shift A and B right by 1.
  - Carry ← adder Cout.
  - Capture the previous carry into the `ovf` source when counter = WIDTH−1.
  - Increment the counter.
  - After the counter = WIDTH−1 cycle, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - `cout` ← final carry.
  - `ovf` ← final carry XOR carry into MSB.
  - Next state is IDLE unconditionally.
- `start` in RUN or DONE is ignored, with no queuing. `a`, `b`, `sub` and `cin` may change freely after acceptance.
- `sum`, `cout` and `ovf` update only at RUN→DONE. They hold their values in IDLE until the next operation completes.
- Counter width is clog2(WIDTH). The counter does not wrap into a new operation; it is reset on each accept.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Shift regs, carry and counter all 0.
- `start` is sampled at edge T0. Bits are processed on edges T1..TWIDTH, and `done` is high in the cycle after TWIDTH.
- Latency from the accept edge to `done` high is WIDTH cycles. `busy` rises the cycle after accept.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is the IDLE cycle following `done`.
- `busy` is high for WIDTH+1 cycles per operation.
- Reset mid-RUN:
  - Everything returns to reset values immediately (asynchronous).
  - No `done` is issued and the partial result is discarded.
- `start` held high continuously: operations are accepted back-to-back at every IDLE cycle.

## Test plan
- Reset then add, `a`=0x5A, `b`=0x3C, `cin`=0 → `done` 8 cycles after accept; `sum`=0x96, `cout`=0, `ovf`=1.
- Add, `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1, `ovf`=0. Then `a`=0x00, `b`=0x00, `cin`=1 → `sum`=0x01, `cout`=0.
- Subtract: `a`=0x10, `b`=0x20 → `sum`=0xF0, `cout`=0 (borrow), `ovf`=0. Then `a`=0x80, `b`=0x01 → `sum`=0x7F, `cout`=1, `ovf`=1.
- `start` pulsed at cycles 3 and 5 after an accept with new operands → the second pulse is ignored; the result matches the first operands only and `done` pulses exactly once.
- `rst_n` asserted at bit 4 of RUN → `busy`, `sum`, `cout` and `ovf` read 0 immediately, with no `done`. A following add of 0x01+0x01 → `sum`=0x02.
- Random sweep of 1000 operations against a reference model, with `start` held high → every result matches and accepts are spaced exactly WIDTH+2 cycles apart.
